// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command packet controller: state codes,
// default start-of-packet byte, error counter width and the checksum rule.
package uart_cmd_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         ERR_CNT_W      = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ADDR  = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_CHK   = 3'd3;
    localparam state_t ST_WRITE = 3'd4;

    function automatic logic [7:0] pkt_checksum(input logic [7:0] hdr,
                                                input logic [7:0] addr,
                                                input logic [7:0] data);
        return hdr ^ addr ^ data;
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags expiry
// on the cycle whose edge would bring the count to TIMEOUT_CYCLES-1; a clear wins.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses HEADER/ADDR/DATA/CHK byte packets into single register writes; outputs are
// registered, wr_en rises one cycle after the CHK byte and holds until wr_ack.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] HEADER         = HEADER_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 wr_en,
    output logic [7:0]           wr_addr,
    output logic [7:0]           wr_data,
    input  logic                 wr_ack,
    output logic                 busy,
    output logic                 pkt_ok,
    output logic                 err_chk,
    output logic                 err_timeout,
    output logic                 err_overrun,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_t     state;
    logic [7:0] addr_q;
    logic [7:0] data_q;

    logic in_pkt;
    logic tmr_clear;
    logic tmr_expire;
    logic chk_bad;
    logic overrun;
    logic err_event;

    assign in_pkt    = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CHK);
    assign tmr_clear = !in_pkt || rx_valid;

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clear),
        .enable(in_pkt),
        .expire(tmr_expire)
    );

    assign chk_bad   = (state == ST_CHK) && rx_valid &&
                       (rx_data != pkt_checksum(HEADER, addr_q, data_q));
    assign overrun   = (state == ST_WRITE) && rx_valid;
    assign err_event = chk_bad || tmr_expire || overrun;

    // Both derive from the state register, so reset drops them without a clock edge.
    assign wr_en = (state == ST_WRITE);
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            wr_addr     <= 8'h00;
            wr_data     <= 8'h00;
            pkt_ok      <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            pkt_ok      <= 1'b0;
            err_chk     <= chk_bad;
            err_timeout <= tmr_expire;
            err_overrun <= overrun;
            case (state)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == HEADER)) begin
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_q <= rx_data;
                        state  <= ST_DATA;
                    end else if (tmr_expire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        data_q <= rx_data;
                        state  <= ST_CHK;
                    end else if (tmr_expire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_CHK: begin
                    if (rx_valid) begin
                        if (chk_bad) begin
                            state <= ST_IDLE;
                        end else begin
                            wr_addr <= addr_q;
                            wr_data <= data_q;
                            state   <= ST_WRITE;
                        end
                    end else if (tmr_expire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    // Bytes arriving here are dropped; only the overrun flag records them.
                    if (wr_ack) begin
                        pkt_ok <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_event && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       busy;
    logic       pkt_ok;
    logic       err_chk;
    logic       err_timeout;
    logic       err_overrun;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int n_ok   = 0;
    int n_err  = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    int   ok0, err0, base, exp_err, gap, ngarb, got;
    logic stable;
    logic bad;
    logic [7:0] a, d, c, m, g;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .HEADER        (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .busy       (busy),
        .pkt_ok     (pkt_ok),
        .err_chk    (err_chk),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .err_count  (err_count)
    );

    // Observed completed writes and error pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (pkt_ok) begin
            n_ok++;
            got_q.push_back({wr_addr, wr_data});
        end
        n_err += int'(err_chk) + int'(err_timeout) + int'(err_overrun);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] pa, input logic [7:0] pd, input logic [7:0] pc);
        send_byte(8'hA5);
        send_byte(pa);
        send_byte(pd);
        send_byte(pc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        wr_ack   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values
        check("rst_flags", {wr_en, busy, pkt_ok, err_chk, err_timeout, err_overrun}, 0);
        check("rst_addr_data", {wr_addr, wr_data}, 16'h0000);
        check("rst_err_count", err_count, 0);

        // Good packet, ack already high: one-cycle write
        wr_ack = 1'b1;
        send_pkt(8'h10, 8'h3C, 8'h89);
        check("good_wr_en", wr_en, 1);
        check("good_addr_data", {wr_addr, wr_data}, 16'h103C);
        check("good_busy", busy, 1);
        @(negedge clk);
        check("good_done", {wr_en, pkt_ok, busy}, 3'b010);
        @(negedge clk);
        check("good_pkt_ok_fall", pkt_ok, 0);
        check("good_err_count", err_count, 0);

        // Leading garbage is discarded silently
        ok0 = n_ok;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_pkt(8'h10, 8'h3C, 8'h89);
        repeat (2) @(negedge clk);
        check("garb_writes", n_ok - ok0, 1);
        check("garb_last_write", got_q[$], 16'h103C);
        check("garb_no_err", n_err, 0);

        // Bad checksum
        send_pkt(8'h10, 8'h3C, 8'h88);
        check("badchk_pulse", {err_chk, wr_en, busy}, 3'b100);
        @(negedge clk);
        check("badchk_fall", err_chk, 0);
        check("badchk_count", err_count, 1);

        // Inter-byte timeout, 99 cycles after the address strobe
        send_byte(8'hA5);
        send_byte(8'h10);
        repeat (TMO - 2) @(negedge clk);
        check("tmo_before", {err_timeout, busy}, 2'b01);
        @(negedge clk);
        check("tmo_pulse", {err_timeout, busy}, 2'b10);
        @(negedge clk);
        check("tmo_fall", err_timeout, 0);
        check("tmo_count", err_count, 2);
        send_pkt(8'h22, 8'h33, 8'hB4);
        check("tmo_recover", {wr_en, wr_addr, wr_data}, {1'b1, 16'h2233});
        @(negedge clk);
        check("tmo_recover_ok", pkt_ok, 1);

        // Stalled ack with an overrun byte in the middle
        wr_ack = 1'b0;
        send_pkt(8'h10, 8'h3C, 8'h89);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            stable &= wr_en && (wr_addr == 8'h10) && (wr_data == 8'h3C);
        end
        send_byte(8'h55);
        check("ovr_pulse", {err_overrun, wr_en}, 2'b11);
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            stable &= wr_en && (wr_addr == 8'h10) && (wr_data == 8'h3C);
        end
        check("ovr_stable", stable, 1);
        check("ovr_count", err_count, 3);
        wr_ack = 1'b1;
        @(negedge clk);
        check("ovr_done", {pkt_ok, wr_en, err_overrun}, 3'b100);
        wr_ack = 1'b0;

        // Reset in the middle of a write
        ok0  = n_ok;
        err0 = n_err;
        send_pkt(8'h5A, 8'hC3, 8'h3C);
        check("rstw_wr_en", wr_en, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rstw_async_flags", {wr_en, busy, pkt_ok, err_chk, err_timeout, err_overrun}, 0);
        check("rstw_regs", {wr_addr, wr_data, err_count}, 24'h0);
        wr_ack = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        wr_ack = 1'b0;
        check("rstw_no_pulses", {n_ok - ok0, n_err - err0}, 64'h0);

        // Randomized packets against a packet-level reference
        base    = got_q.size();
        exp_err = 0;
        for (int p = 0; p < 24; p++) begin
            ngarb = $urandom_range(0, 2);
            for (int k = 0; k < ngarb; k++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g);
            end
            a   = 8'($urandom);
            d   = 8'($urandom);
            bad = ($urandom_range(0, 2) == 0);
            m   = 8'($urandom_range(1, 255));
            c   = 8'hA5 ^ a ^ d;
            if (bad) c = c ^ m;
            send_pkt(a, d, c);
            if (bad) begin
                exp_err++;
            end else begin
                exp_q.push_back({a, d});
                gap = $urandom_range(0, 4);
                repeat (gap) @(negedge clk);
                wr_ack = 1'b1;
                got = 0;
                for (int k = 0; k < 10 && got == 0; k++) begin
                    @(negedge clk);
                    if (pkt_ok) got = 1;
                end
                wr_ack = 1'b0;
                check("rnd_pkt_ok", got, 1);
            end
        end
        @(negedge clk);
        check("rnd_nwrites", got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) check("rnd_write", got_q[base + i], exp_q[i]);
        end
        check("rnd_err_count", err_count, exp_err);

        // Saturation of the error counter
        for (int p = 0; p < 260; p++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            send_pkt(a, d, 8'hA5 ^ a ^ d ^ 8'h01);
        end
        @(negedge clk);
        check("sat_err_count", err_count, (exp_err + 260 > 255) ? 255 : exp_err + 260);
        check("sat_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
